// File: rtl/gs_pkg.sv
// ---------------------------------------------------------------------------
// gs_pkg
// Shared definitions for the 3x3 window sequencer that feeds the grayscale
// register bank.
//   TAP_NUM / TAP_W : number of window taps and width of a tap index
//   PIX_W           : RGB pixel width {R,G,B}
//   gs_state_e      : sequencer states
//   TAP_DX / TAP_DY : column / row offset of each tap relative to the centre,
//                     taps ordered row-major from the top-left neighbour
// ---------------------------------------------------------------------------
package gs_pkg;

    localparam int TAP_NUM = 9;
    localparam int TAP_W   = 4;
    localparam int PIX_W   = 24;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        VALID,
        DONE
    } gs_state_e;

    localparam int TAP_DX [TAP_NUM] = '{-1,  0,  1, -1, 0, 1, -1, 0, 1};
    localparam int TAP_DY [TAP_NUM] = '{-1, -1, -1,  0, 0, 0,  1, 1, 1};

endpackage

// File: rtl/gs_tap_addr.sv
// ---------------------------------------------------------------------------
// gs_tap_addr
// Combinational address generator for one window tap. The neighbour
// coordinate is clamped into the image before the row-major multiply, so the
// address can never wrap or point outside the image memory.
// Ports:
//   cx_i, cy_i  : centre pixel coordinate
//   tap_i       : tap index 0..8
//   addr_o      : clamped image memory address, y*IMG_W + x
//   oob_o       : the unclamped neighbour lies outside the image
// ---------------------------------------------------------------------------
module gs_tap_addr
    import gs_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 6
) (
    input  logic [AW-1:0]    cx_i,
    input  logic [AW-1:0]    cy_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [AW-1:0]    addr_o,
    output logic             oob_o
);

    int dx;
    int dy;
    int rawX;
    int rawY;
    int clampX;
    int clampY;

    // Offset the centre by the tap's table entry, flag border taps, then
    // clamp each axis to the edge pixel before forming the address.
    always_comb begin
        dx = 0;
        dy = 0;
        if (int'(tap_i) < TAP_NUM) begin
            dx = TAP_DX[tap_i];
            dy = TAP_DY[tap_i];
        end
        rawX = int'(cx_i) + dx;
        rawY = int'(cy_i) + dy;

        oob_o = (rawX < 0) || (rawX > IMG_W - 1) ||
                (rawY < 0) || (rawY > IMG_H - 1);

        if (rawX < 0)              clampX = 0;
        else if (rawX > IMG_W - 1) clampX = IMG_W - 1;
        else                       clampX = rawX;

        if (rawY < 0)              clampY = 0;
        else if (rawY > IMG_H - 1) clampY = IMG_H - 1;
        else                       clampY = rawY;

        addr_o = AW'(clampY * IMG_W + clampX);
    end

endmodule

// File: rtl/gs_window_ctrl.sv
// ---------------------------------------------------------------------------
// gs_window_ctrl
// Raster-scans an IMG_W x IMG_H RGB image and, for every centre pixel,
// fetches its 3x3 neighbourhood into the 9-entry grayscale bank, then offers
// the complete window to the downstream 3x3 filter.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i             : begin a full-frame scan (only looked at in IDLE)
//   busy_o, done_o      : scan in progress / one-cycle end-of-frame pulse
//   ird_o, iaddr_o      : image memory read strobe and address
//   idata_i             : image read data, valid the cycle after ird_o
//   gs_en_o, gs_addr_o,
//   gs_d_o              : grayscale bank write port
//   win_valid_o,
//   win_ready_i         : window handshake with the filter stage
//   cx_o, cy_o          : centre of the window currently in the bank
// Build option:
//   GS_BORDER_ZERO_EN   : taps outside the image are zero padded and no read
//                         is issued for them; otherwise the edge pixel is
//                         replicated.
// ---------------------------------------------------------------------------
module gs_window_ctrl
    import gs_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ird_o,
    output logic [AW-1:0]    iaddr_o,
    input  logic [PIX_W-1:0] idata_i,
    output logic             gs_en_o,
    output logic [3:0]       gs_addr_o,
    output logic [PIX_W-1:0] gs_d_o,
    output logic             win_valid_o,
    input  logic             win_ready_i,
    output logic [AW-1:0]    cx_o,
    output logic [AW-1:0]    cy_o
);

`ifdef GS_BORDER_ZERO_EN
    localparam bit BorderZero = 1'b1;
`else
    localparam bit BorderZero = 1'b0;
`endif

    gs_state_e        state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [AW-1:0]    cx_q, cx_d;
    logic [AW-1:0]    cy_q, cy_d;
    logic             wbValid_q, wbValid_d;
    logic [TAP_W-1:0] wbTap_q, wbTap_d;
    logic             wbOob_q, wbOob_d;
    logic [AW-1:0]    iaddr_q;

    logic [AW-1:0]    tapAddr;
    logic             tapOob;

    gs_tap_addr #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_tap_addr (
        .cx_i   (cx_q),
        .cy_i   (cy_q),
        .tap_i  (tap_q),
        .addr_o (tapAddr),
        .oob_o  (tapOob)
    );

    // State, counters and the one-deep writeback pipeline. iaddr_q remembers
    // the last issued address so the port holds steady when no read goes out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            wbValid_q <= 1'b0;
            wbTap_q   <= '0;
            wbOob_q   <= 1'b0;
            iaddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            wbValid_q <= wbValid_d;
            wbTap_q   <= wbTap_d;
            wbOob_q   <= wbOob_d;
            iaddr_q   <= iaddr_o;
        end
    end

    // Next-state and read-side decode. Each FETCH cycle issues one tap read
    // and queues its writeback for the following cycle, so tap 8 lands in
    // DRAIN. The centre only moves on the accepting edge in VALID; the final
    // centre resets the scan position on its way to DONE.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        wbValid_d = 1'b0;
        wbTap_d   = tap_q;
        wbOob_d   = tapOob;
        ird_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    tap_d   = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            FETCH: begin
                ird_o     = !(BorderZero && tapOob);
                wbValid_d = 1'b1;
                if (tap_q == TAP_W'(TAP_NUM - 1)) begin
                    state_d = DRAIN;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            DRAIN: begin
                state_d = VALID;
            end
            VALID: begin
                if (win_ready_i) begin
                    tap_d = '0;
                    if (cx_q == AW'(IMG_W - 1)) begin
                        cx_d = '0;
                        if (cy_q == AW'(IMG_H - 1)) begin
                            cy_d    = '0;
                            state_d = DONE;
                        end else begin
                            cy_d    = cy_q + AW'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        cx_d    = cx_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        iaddr_o = ird_o ? tapAddr : iaddr_q;
    end

    // Bank write port follows the pipeline; padded taps write zero.
    assign gs_en_o   = wbValid_q;
    assign gs_addr_o = wbValid_q ? wbTap_q : '0;
    assign gs_d_o    = (wbValid_q && !(BorderZero && wbOob_q)) ? idata_i : '0;

    // Status and window handshake decode straight from the state register.
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign win_valid_o = (state_q == VALID);
    assign cx_o        = cx_q;
    assign cy_o        = cy_q;

endmodule
